// File: rtl/data_memory.sv
// Word-addressed 32-bit single-port data memory: synchronous write, registered write-first read.
// Optional range checking with an addr_err output is enabled by defining MEMORY_ADDR_CHECK_EN.
module data_memory #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        wn,
  input  logic        rd,
`ifdef MEMORY_ADDR_CHECK_EN
  output logic        addr_err,
`endif
  output logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_read_data;
  logic [AW-1:0] w_index;
  logic          w_in_range;
  logic          w_wr_en;
  logic          w_rd_en;

  assign w_index = address[AW-1:0];

`ifdef MEMORY_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_in_range = (address < 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= (wn || rd) && !w_in_range;
    end
  end

  assign addr_err = r_addr_err;
`else
  // Upper address bits are ignored, so accesses alias modulo DEPTH.
  assign w_in_range = 1'b1;
`endif

  assign w_wr_en = wn && w_in_range;
  assign w_rd_en = rd && w_in_range;

  // Each word is its own register so the whole array clears on reset without a clock.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= 32'h0;
        end else if (w_wr_en && (w_index == AW'(gi))) begin
          r_mem[gi] <= write_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data <= 32'h0;
    end else if (w_rd_en) begin
      r_read_data <= wn ? write_data : r_mem[w_index];
    end
  end

  assign read_data = r_read_data;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; covers reset, write/read, hold, write-first,
// asynchronous mid-operation reset, and address wrap or range checking (MEMORY_ADDR_CHECK_EN).
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        wn;
  logic        rd;
  logic [31:0] read_data;
`ifdef MEMORY_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int vectors;
  int miscompares;

  data_memory #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .write_data (write_data),
    .wn         (wn),
    .rd         (rd),
`ifdef MEMORY_ADDR_CHECK_EN
    .addr_err   (addr_err),
`endif
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one access at the negedge, let the posedge take it, return at the next negedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    address    = a;
    write_data = d;
    wn         = w;
    rd         = r;
    @(posedge clk);
    @(negedge clk);
    address    = 32'h0;
    write_data = 32'h0;
    wn         = 1'b0;
    rd         = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("vec %0d %s: read 0x%08h want 0x%08h", vectors, tag, obs, exp);
  endtask

  initial begin
    logic [31:0] wr_vals [5];
    vectors     = 0;
    miscompares = 0;
    wr_vals[0] = 32'h0;
    wr_vals[1] = 32'h1;
    wr_vals[2] = 32'h10;
    wr_vals[3] = 32'h6;
    wr_vals[4] = 32'h12;

    rst_n      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    wn         = 1'b0;
    rd         = 1'b0;
    @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
`ifdef MEMORY_ADDR_CHECK_EN
    check("reset_addr_err", {31'h0, addr_err}, 32'h0);
`endif

    // Access presented while reset is held must be dropped.
    cycle(32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("access_in_reset", read_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cycle(32'(i), 32'h0, 1'b0, 1'b1);
      check($sformatf("post_reset_rd%0d", i), read_data, 32'h0);
    end

    for (int i = 0; i < 5; i++) begin
      cycle(32'(i), wr_vals[i], 1'b1, 1'b0);
    end
    check("write_no_rd_hold", read_data, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(32'(i), 32'h0, 1'b0, 1'b1);
      check($sformatf("readback%0d", i), read_data, wr_vals[i]);
    end

    cycle(32'h3, 32'h0, 1'b0, 1'b1);
    check("read3", read_data, 32'h6);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h0, 32'h0, 1'b0, 1'b0);
      check($sformatf("hold%0d", i), read_data, 32'h6);
    end

    cycle(32'h3, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("write_first", read_data, 32'hDEAD_BEEF);
    cycle(32'h2, 32'h0, 1'b0, 1'b1);
    check("read2", read_data, 32'h10);
    cycle(32'h3, 32'h0, 1'b0, 1'b1);
    check("read3_new", read_data, 32'hDEAD_BEEF);

    // Reset pulse between edges clears immediately, without a clock.
    #2 rst_n = 1'b0;
    #1 check("async_reset", read_data, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cycle(32'h2, 32'h0, 1'b0, 1'b1);
    check("after_reset_rd2", read_data, 32'h0);
    cycle(32'h3, 32'h0, 1'b0, 1'b1);
    check("after_reset_rd3", read_data, 32'h0);

`ifdef MEMORY_ADDR_CHECK_EN
    cycle(32'h1, 32'h77, 1'b1, 1'b1);
    check("inrange_wr_rd", read_data, 32'h77);
    cycle(32'h100, 32'hA5, 1'b1, 1'b0);
    check("oor_write_err", {31'h0, addr_err}, 32'h1);
    cycle(32'h0, 32'h0, 1'b0, 1'b1);
    check("addr0_unchanged", read_data, 32'h0);
    check("inrange_err_clr", {31'h0, addr_err}, 32'h0);
    cycle(32'h1, 32'h0, 1'b0, 1'b1);
    check("read1", read_data, 32'h77);
    cycle(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    check("oor_read_hold", read_data, 32'h77);
    check("oor_read_err", {31'h0, addr_err}, 32'h1);
    cycle(32'h0, 32'h0, 1'b0, 1'b0);
    check("idle_err_clr", {31'h0, addr_err}, 32'h0);
`else
    cycle(32'h100, 32'hA5, 1'b1, 1'b0);
    cycle(32'h0, 32'h0, 1'b0, 1'b1);
    check("wrap_0x100", read_data, 32'hA5);
    cycle(32'h1FF, 32'h5A, 1'b1, 1'b0);
    cycle(32'hFF, 32'h0, 1'b0, 1'b1);
    check("wrap_0x1ff", read_data, 32'h5A);
    cycle(32'h1, 32'h0, 1'b0, 1'b1);
    check("no_alias_1", read_data, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
